lane_frame_loader: RTL and testbench
====================================

# lane_frame_loader

Deserializes a byte stream (valid/ready, with last marker) into a frame of NUM_LANES parallel byte lanes. It feeds the wide multi-lane compute modules, lane 0 driving the `data_a` input and lane 25 driving `data_z`. Completed frames are presented with a valid/ready hold, and malformed or stalled frames are dropped with error pulses. It is the producer side of the 26×8-bit lane interface.

## Interface
- NUM_LANES, 26, number of byte lanes per frame (≥2)
- LANE_W, 8, lane width in bits
- TIMEOUT, 255, idle cycles tolerated mid-frame before abort (≥1)

- clk_i  input  1  single clock, all logic rising-edge
- rst_i  input  1  reset, synchronous, active-high
- s_data_i  input  LANE_W  stream byte
- s_valid_i  input  1  stream byte valid
- s_last_i  input  1  marks final byte of a frame
- s_ready_o  output  1  loader accepts a byte this cycle
- lanes_o  output  NUM_LANES*LANE_W  lane k at bits [k*LANE_W +: LANE_W]
- frame_valid_o  output  1  lanes_o holds a complete frame
- frame_ready_i  input  1  consumer takes the frame
- err_len_o  output  1  one-cycle pulse, frame dropped for a length error
- err_tmo_o  output  1  one-cycle pulse, frame dropped for a timeout
- frame_cnt_o  output  16  delivered-frame count, wraps at 0xFFFF→0

## Operation
- Accept: s_valid_i && s_ready_o. Byte goes to lane idx, then idx increments.
- Index: idx is a ceil(log2(NUM_LANES))-bit counter.
- FSM states: FILL, DRAIN, HOLD. Reset enters FILL with idx=0.
- FILL:
  - s_ready_o=1.
  - Accept with s_last_i=1 and idx<NUM_LANES-1 (short frame): pulse err_len_o, idx←0, stay in FILL. The partial lanes are not presented.
  - Accept at idx=NUM_LANES-1 with s_last_i=1: go to HOLD.
  - Accept at idx=NUM_LANES-1 with s_last_i=0 (long frame): pulse err_len_o, go to DRAIN.
- DRAIN:
  - s_ready_o=1. Accepted bytes are discarded.
  - Accept with s_last_i=1: idx←0, go to FILL. No second error pulse.
- HOLD:
  - s_ready_o=0, frame_valid_o=1, lanes_o stable.
  - frame_valid_o && frame_ready_i: frame_cnt_o+1, idx←0, go to FILL.
- Timeout: idle counter runs in FILL when idx>0, and in DRAIN.
  - Clears on every accept.
  - Reaching TIMEOUT consecutive non-accept cycles: pulse err_tmo_o, idx←0, go to FILL.
  - Never runs in HOLD.
- lanes_o is only meaningful while frame_valid_o=1. Lanes may change during FILL.
- Lanes are not cleared between frames.
- err_len_o and err_tmo_o never assert in the same cycle.

## Timing
- Reset values: s_ready_o=0 while rst_i=1. lanes_o=0, frame_valid_o=0, err_len_o=0, err_tmo_o=0, frame_cnt_o=0.
- s_ready_o=1 from the first cycle after rst_i deasserts.
- All outputs are registered, except s_ready_o, which is decoded combinationally from the state register.
- Latency: frame_valid_o rises the cycle after the final byte is accepted.
- Throughput: at most one frame per NUM_LANES+1 cycles, since the HOLD handshake cycle takes no byte.
- frame_valid_o must not drop without a handshake. A consumer may hold frame_ready_i high permanently.
- Error pulses assert the cycle after the offending accept or timeout expiry, for exactly one cycle.
- rst_i mid-frame or in HOLD: the next cycle shows reset values and the pending frame is lost.
- frame_cnt_o wrap: 0xFFFF plus one delivery gives 0x0000, with no flag.

## Structure
- Package lane_loader_pkg holds:
  - typedef enum {FILL, DRAIN, HOLD} loader_state_t
  - localparams LL_NUM_LANES_DEF=26, LL_LANE_W_DEF=8, LL_CNT_W=16
- Sub-module lane_idle_timer:
  - inputs: clk_i, rst_i, run_i, clear_i
  - output: expire_o, pulsed when the count reaches TIMEOUT
  - the count saturates until cleared
- Top-level holds the FSM, the idx counter, the lane register array and the frame counter.

## Test plan
- 26 bytes 0x01..0x1A, last on the 26th, frame_ready_i=1:
  - frame_valid_o rises one cycle after the 26th accept.
  - lanes_o[7:0]=0x01 and lanes_o[207:200]=0x1A.
  - frame_cnt_o=1.
- Same frame with frame_ready_i=0 for 10 cycles: frame_valid_o stays 1 and s_ready_o stays 0 for 10 cycles. lanes_o is unchanged until the handshake.
- Last on the 5th byte, then a good frame 0xA0..0xB9: err_len_o pulses once. The next frame is delivered with lane 0=0xA0.
- 30 bytes with last on the 30th: err_len_o pulses after the 26th byte, and bytes 27–30 are discarded. No frame_valid_o; the next frame is clean.
- 3 bytes, then s_valid_i=0 for 255 cycles: err_tmo_o pulses exactly once. A following 26-byte frame loads lane 0 from its first byte.
- rst_i for one cycle in HOLD, and frame_cnt_o preset to 0xFFFF by 65535 deliveries:
  - Reset case: outputs return to reset values.
  - Wrap case: one further delivery gives frame_cnt_o=0.

Source files
------------

// File: rtl/lane_loader_pkg.sv
// Shared types and default sizes for the byte-stream to lane-frame loader.
package lane_loader_pkg;

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} loader_state_t;

    localparam int LL_NUM_LANES_DEF = 26;
    localparam int LL_LANE_W_DEF    = 8;
    localparam int LL_CNT_W         = 16;

endpackage

// File: rtl/lane_idle_timer.sv
// Counts consecutive idle cycles while running; flags the cycle that reaches TIMEOUT.
module lane_idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Saturates at TIMEOUT so a stalled stream fires exactly once.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lane_frame_loader.sv
// Deserializes a valid/ready byte stream into a NUM_LANES-wide frame held until taken.
module lane_frame_loader
    import lane_loader_pkg::*;
#(
    parameter int NUM_LANES = LL_NUM_LANES_DEF,
    parameter int LANE_W    = LL_LANE_W_DEF,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LANE_W-1:0]           s_data_i,
    input  logic                        s_valid_i,
    input  logic                        s_last_i,
    output logic                        s_ready_o,
    output logic [NUM_LANES*LANE_W-1:0] lanes_o,
    output logic                        frame_valid_o,
    input  logic                        frame_ready_i,
    output logic                        err_len_o,
    output logic                        err_tmo_o,
    output logic [LL_CNT_W-1:0]         frame_cnt_o
);

    localparam int                IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LANES - 1);

    loader_state_t                     state_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [NUM_LANES-1:0][LANE_W-1:0]  lanes_q;
    logic                              frame_valid_q;
    logic                              err_len_q;
    logic                              err_tmo_q;
    logic [LL_CNT_W-1:0]               frame_cnt_q;

    logic accept;
    logic tmr_run;
    logic tmr_expire;

    // Ready is held low during reset so nothing is taken before the FSM is defined.
    assign s_ready_o = !rst_i && (state_q != HOLD);
    assign accept    = s_valid_i && s_ready_o;
    assign tmr_run   = ((state_q == FILL) && (idx_q != '0)) || (state_q == DRAIN);

    lane_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run_i    (tmr_run),
        .clear_i  (accept),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FILL;
            idx_q         <= '0;
            lanes_q       <= '0;
            frame_valid_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_tmo_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        lanes_q[idx_q] <= s_data_i;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (s_last_i) begin
                                state_q       <= HOLD;
                                frame_valid_q <= 1'b1;
                            end else begin
                                state_q   <= DRAIN;
                                err_len_q <= 1'b1;
                            end
                        end else if (s_last_i) begin
                            idx_q     <= '0;
                            err_len_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (tmr_expire) begin
                        idx_q     <= '0;
                        err_tmo_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Overlong tail is swallowed up to its last marker; the error already fired.
                    if (accept && s_last_i) begin
                        state_q <= FILL;
                        idx_q   <= '0;
                    end else if (!accept && tmr_expire) begin
                        state_q   <= FILL;
                        idx_q     <= '0;
                        err_tmo_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_ready_i) begin
                        state_q       <= FILL;
                        idx_q         <= '0;
                        frame_valid_q <= 1'b0;
                        frame_cnt_q   <= frame_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q       <= FILL;
                    idx_q         <= '0;
                    frame_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign lanes_o       = lanes_q;
    assign frame_valid_o = frame_valid_q;
    assign err_len_o     = err_len_q;
    assign err_tmo_o     = err_tmo_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_lane_frame_loader.sv
// Bench for lane_frame_loader: directed table, corner sequences and random traffic vs a queue model.
module tb_lane_frame_loader;

    localparam int N   = 26;
    localparam int W   = 8;
    localparam int TMO = 255;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [W-1:0]     s_data_i;
    logic             s_valid_i;
    logic             s_last_i;
    logic             s_ready_o;
    logic [N*W-1:0]   lanes_o;
    logic             frame_valid_o;
    logic             frame_ready_i;
    logic             err_len_o;
    logic             err_tmo_o;
    logic [15:0]      frame_cnt_o;

    lane_frame_loader #(
        .NUM_LANES (N),
        .LANE_W    (W),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .lanes_o       (lanes_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .err_len_o     (err_len_o),
        .err_tmo_o     (err_tmo_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bytes of the frame in progress plus a few flags.
    logic [7:0]     cur[$];
    bit             m_drop, m_hold, m_elen, m_etmo;
    int             m_idle;
    logic [15:0]    m_cnt;
    logic [N*W-1:0] m_frame;

    int             ev_len, ev_tmo, ev_deliv;
    logic [N*W-1:0] got_lanes;

    typedef struct {
        int         len;
        logic [7:0] base;
        int         exp_len;
        int         exp_deliv;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        cur.delete();
        m_drop = 0; m_hold = 0; m_elen = 0; m_etmo = 0;
        m_idle = 0; m_cnt = '0; m_frame = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic l, input logic r);
        m_elen = 0;
        m_etmo = 0;
        if (m_hold) begin
            if (r) begin m_hold = 0; m_cnt = m_cnt + 16'd1; end
        end else if (v) begin
            m_idle = 0;
            if (m_drop) begin
                if (l) m_drop = 0;
            end else begin
                cur.push_back(d);
                if (cur.size() == N) begin
                    if (l) begin
                        for (int k = 0; k < N; k++) m_frame[k*W +: W] = cur[k];
                        m_hold = 1;
                    end else begin
                        m_elen = 1;
                        m_drop = 1;
                    end
                    cur.delete();
                end else if (l) begin
                    m_elen = 1;
                    cur.delete();
                end
            end
        end else if (m_drop || cur.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_etmo = 1; m_idle = 0; m_drop = 0;
                cur.delete();
            end
        end
    endtask

    function automatic logic rnd_r(input int m);
        return (m == 2) ? 1'($urandom_range(0, 1)) : (m == 1);
    endfunction

    // One clock: drive, compare all outputs against the model, advance.
    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r, output bit acc);
        logic [N*W-1:0] zero;
        zero = '0;
        s_valid_i = v; s_data_i = d; s_last_i = l; frame_ready_i = r;
        #1;
        check("cycle",
              256'({s_ready_o, frame_valid_o, err_len_o, err_tmo_o, frame_cnt_o, (m_hold ? lanes_o : zero)}),
              256'({!m_hold, m_hold, m_elen, m_etmo, m_cnt, (m_hold ? m_frame : zero)}));
        if (err_len_o) ev_len++;
        if (err_tmo_o) ev_tmo++;
        if (frame_valid_o && frame_ready_i) begin ev_deliv++; got_lanes = lanes_o; end
        acc = v && !m_hold;
        model_step(v, d, l, r);
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n, input int rmode);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, rnd_r(rmode), acc);
    endtask

    task automatic send_bytes(input logic [7:0] base, input int count, input bit last_fin,
                              input int rmode, input int maxgap);
        bit acc;
        int tries;
        for (int i = 0; i < count; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(0, maxgap)), rmode);
            tries = 0;
            acc   = 0;
            while (!acc) begin
                cyc(1'b1, 8'(base + i), last_fin && (i == count - 1), rnd_r(rmode), acc);
                tries++;
                if (!acc && tries > 200) begin
                    n_chk++;
                    $display("FAIL accept-bound: byte %0d not accepted within 200 cycles", i);
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [N*W-1:0] exp_frame;
        bit             hold_ok;
        bit             acc;

        vecs[0] = '{5,  8'h01, 1, 0};
        vecs[1] = '{26, 8'hA0, 0, 1};
        vecs[2] = '{30, 8'h40, 1, 0};
        vecs[3] = '{26, 8'h60, 0, 1};
        vecs[4] = '{1,  8'h10, 1, 0};
        vecs[5] = '{25, 8'h20, 1, 0};
        vecs[6] = '{27, 8'h30, 1, 0};
        vecs[7] = '{52, 8'hC0, 1, 0};
        vecs[8] = '{26, 8'hE0, 0, 1};

        rst_i = 1'b1; s_valid_i = 0; s_data_i = '0; s_last_i = 0; frame_ready_i = 0;
        ev_len = 0; ev_tmo = 0; ev_deliv = 0; got_lanes = '0;
        model_reset();
        @(posedge clk_i); #1;
        check("ready in reset", 256'(s_ready_o), 256'(0));
        @(posedge clk_i); #1;
        check("reset outputs", 256'({frame_valid_o, err_len_o, err_tmo_o, frame_cnt_o, lanes_o}), 256'(0));
        rst_i = 1'b0;
        #1;
        check("ready after reset", 256'(s_ready_o), 256'(1));

        // Basic frame 0x01..0x1A with consumer always ready.
        send_bytes(8'h01, N, 1, 1, 0);
        check("valid latency", 256'(frame_valid_o), 256'(1));
        check("lane0", 256'(lanes_o[7:0]), 256'(8'h01));
        check("lane25", 256'(lanes_o[(N-1)*W +: W]), 256'(8'h1A));
        idle(1, 1);
        check("frame cnt 1", 256'(frame_cnt_o), 256'(1));
        check("valid dropped", 256'(frame_valid_o), 256'(0));

        // Consumer stalls 10 cycles.
        for (int k = 0; k < N; k++) exp_frame[k*W +: W] = 8'(k + 1);
        send_bytes(8'h01, N, 1, 0, 0);
        hold_ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (!(frame_valid_o === 1'b1 && s_ready_o === 1'b0 && lanes_o === exp_frame)) hold_ok = 0;
            idle(1, 0);
        end
        check("hold stable 10 cycles", 256'(hold_ok), 256'(1));
        idle(1, 1);
        check("frame cnt 2", 256'(frame_cnt_o), 256'(2));

        // Table of frame lengths.
        for (int i = 0; i < 9; i++) begin
            ev_len = 0; ev_deliv = 0;
            send_bytes(vecs[i].base, vecs[i].len, 1, 1, 0);
            idle(3, 1);
            check($sformatf("vec%0d err_len", i), 256'(ev_len), 256'(vecs[i].exp_len));
            check($sformatf("vec%0d deliv", i), 256'(ev_deliv), 256'(vecs[i].exp_deliv));
            if (vecs[i].exp_deliv != 0) begin
                check($sformatf("vec%0d lane0", i), 256'(got_lanes[7:0]), 256'(vecs[i].base));
                check($sformatf("vec%0d lane25", i), 256'(got_lanes[(N-1)*W +: W]),
                      256'(8'(vecs[i].base + 8'd25)));
            end
        end

        // Timeout after 3 bytes and exactly TMO idle cycles.
        ev_tmo = 0; ev_deliv = 0;
        send_bytes(8'h30, 3, 0, 1, 0);
        idle(TMO - 1, 1);
        check("no early timeout", 256'(err_tmo_o), 256'(0));
        idle(1, 1);
        check("tmo pulse", 256'(err_tmo_o), 256'(1));
        idle(1, 1);
        check("tmo single", 256'(err_tmo_o), 256'(0));
        send_bytes(8'h77, N, 1, 1, 0);
        idle(2, 1);
        check("tmo count", 256'(ev_tmo), 256'(1));
        check("after tmo lane0", 256'(got_lanes[7:0]), 256'(8'h77));
        check("after tmo deliv", 256'(ev_deliv), 256'(1));

        // TMO-1 idle cycles mid-frame are tolerated.
        ev_tmo = 0; ev_deliv = 0;
        send_bytes(8'h50, 3, 0, 1, 0);
        idle(TMO - 1, 1);
        send_bytes(8'h53, N - 3, 1, 1, 0);
        idle(2, 1);
        check("near-tmo no err", 256'(ev_tmo), 256'(0));
        check("near-tmo lane0", 256'(got_lanes[7:0]), 256'(8'h50));
        check("near-tmo lane25", 256'(got_lanes[(N-1)*W +: W]), 256'(8'h69));

        // Reset while holding a frame.
        send_bytes(8'h01, N, 1, 0, 0);
        check("hold before reset", 256'(frame_valid_o), 256'(1));
        rst_i = 1'b1; s_valid_i = 0; frame_ready_i = 0;
        #1;
        check("ready in hold reset", 256'(s_ready_o), 256'(0));
        @(posedge clk_i); #1;
        check("reset in hold", 256'({frame_valid_o, err_len_o, err_tmo_o, frame_cnt_o, lanes_o}), 256'(0));
        rst_i = 1'b0;
        model_reset();
        #1;
        check("ready after hold reset", 256'(s_ready_o), 256'(1));
        idle(3, 1);

        // Counter wrap: preload the count as if 65535 frames had been delivered.
        dut.frame_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        send_bytes(8'h11, N, 1, 1, 0);
        idle(1, 1);
        check("cnt wrap", 256'(frame_cnt_o), 256'(0));

        // Random traffic against the model.
        for (int f = 0; f < 80; f++) begin
            int len;
            case ($urandom_range(0, 8))
                0:       len = 5;
                1:       len = 30;
                2:       len = 1;
                3:       len = 25;
                4:       len = 27;
                default: len = N;
            endcase
            if (f % 15 == 7) begin
                send_bytes(8'($urandom), 4, 0, 2, 1);
                idle(TMO + 5, 2);
            end
            send_bytes(8'($urandom), len, 1, 2, 2);
            idle(int'($urandom_range(0, 3)), 2);
        end
        idle(4, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
